// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: assembles RV32I words from field tuples and writes
// them to sequential instruction-memory word addresses.
// Optional feature macro: PAD_NOP_EN (pad unwritten words with NOP_WORD).
module instr_encoder_loader #(
    parameter int unsigned AW       = 6,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    input  logic [2:0]    cls,
    input  logic [4:0]    rd,
    input  logic [4:0]    rs1,
    input  logic [4:0]    rs2,
    input  logic [2:0]    funct3,
    input  logic          f7b5,
    input  logic [20:0]   imm,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          err,
    output logic          err_sticky,
    output logic          done,
    output logic [AW:0]   count
);

    localparam int unsigned CW = AW + 1;
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    localparam logic [2:0] ClsLoad   = 3'b000;
    localparam logic [2:0] ClsStore  = 3'b001;
    localparam logic [2:0] ClsR      = 3'b010;
    localparam logic [2:0] ClsBranch = 3'b011;
    localparam logic [2:0] ClsJal    = 3'b100;
    localparam logic [2:0] ClsOpImm  = 3'b101;

`ifdef PAD_NOP_EN
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, PAD = 2'd2, DONE = 2'd3} stateT;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd3} stateT;
`endif

    stateT           stateQ, stateD;
    logic [AW:0]     countQ, countD;
    logic            lastPendQ, lastPendD;
    logic            memWeQ, memWeD;
    logic [AW-1:0]   memAddrQ, memAddrD;
    logic [31:0]     memWdataQ, memWdataD;
    logic            errQ, errD;
    logic            errStickyQ, errStickyD;
    logic            inReadyQ, inReadyD;
    logic            doneQ, doneD;

    logic [31:0]     encWord;
    logic            immOk;
    logic            fits12;
    logic            fits13;
    logic            accept;

    assign accept = in_valid && inReadyQ;

    // Field placement and immediate range check per instruction class.
    always_comb begin
        encWord = NOP_WORD;
        immOk   = 1'b0;
        fits12  = (imm[20:11] == {10{imm[11]}});
        fits13  = (imm[20:12] == {9{imm[12]}});
        case (cls)
            ClsLoad: begin
                encWord = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
                immOk   = fits12;
            end
            ClsStore: begin
                encWord = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
                immOk   = fits12;
            end
            ClsR: begin
                encWord = {1'b0, f7b5, 5'b00000, rs2, rs1, funct3, rd, 7'b0110011};
                immOk   = 1'b1;
            end
            ClsBranch: begin
                encWord = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
                immOk   = fits13 && !imm[0];
            end
            ClsJal: begin
                encWord = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
                immOk   = !imm[0];
            end
            ClsOpImm: begin
                encWord = {imm[11:0], rs1, funct3, rd, 7'b0010011};
                immOk   = fits12;
            end
            default: begin
                encWord = NOP_WORD;
                immOk   = 1'b0;
            end
        endcase
    end

    // Next-state, write-port and status logic.
    always_comb begin
        stateD     = stateQ;
        countD     = countQ;
        lastPendD  = lastPendQ;
        memWeD     = 1'b0;
        memAddrD   = memAddrQ;
        memWdataD  = memWdataQ;
        errD       = 1'b0;
        errStickyD = errStickyQ;
        case (stateQ)
            IDLE, DONE: begin
                if (start) begin
                    stateD     = LOAD;
                    countD     = '0;
                    lastPendD  = 1'b0;
                    errStickyD = 1'b0;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (immOk) begin
                        memWeD    = 1'b1;
                        memAddrD  = countQ[AW-1:0];
                        memWdataD = encWord;
                        countD    = countQ + CW'(1);
                    end else begin
                        errD       = 1'b1;
                        errStickyD = 1'b1;
                    end
                    if (in_last) begin
`ifdef PAD_NOP_EN
                        // A load that ends full goes to DONE without padding.
                        if (countD < DEPTH) stateD = PAD;
                        else                lastPendD = 1'b1;
`else
                        lastPendD = 1'b1;
`endif
                    end
                end else if (lastPendQ || (countQ == DEPTH)) begin
                    stateD = DONE;
                end
            end
`ifdef PAD_NOP_EN
            PAD: begin
                if (countQ < DEPTH) begin
                    memWeD    = 1'b1;
                    memAddrD  = countQ[AW-1:0];
                    memWdataD = NOP_WORD;
                    countD    = countQ + CW'(1);
                end else begin
                    stateD = DONE;
                end
            end
`endif
            default: stateD = IDLE;
        endcase
        inReadyD = (stateD == LOAD) && !lastPendD && (countD < DEPTH);
        doneD    = (stateD == DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ     <= IDLE;
            countQ     <= '0;
            lastPendQ  <= 1'b0;
            memWeQ     <= 1'b0;
            memAddrQ   <= '0;
            memWdataQ  <= '0;
            errQ       <= 1'b0;
            errStickyQ <= 1'b0;
            inReadyQ   <= 1'b0;
            doneQ      <= 1'b0;
        end else begin
            stateQ     <= stateD;
            countQ     <= countD;
            lastPendQ  <= lastPendD;
            memWeQ     <= memWeD;
            memAddrQ   <= memAddrD;
            memWdataQ  <= memWdataD;
            errQ       <= errD;
            errStickyQ <= errStickyD;
            inReadyQ   <= inReadyD;
            doneQ      <= doneD;
        end
    end

    assign in_ready   = inReadyQ;
    assign mem_we     = memWeQ;
    assign mem_addr   = memAddrQ;
    assign mem_wdata  = memWdataQ;
    assign err        = errQ;
    assign err_sticky = errStickyQ;
    assign done       = doneQ;
    assign count      = countQ;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: three instances (AW=6, 2, 3)
// share the tuple stream; each has its own start and its own write scoreboard.
module tb_instr_encoder_loader;

    typedef struct packed {
        logic [5:0]  a;
        logic [31:0] d;
    } expT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start6, start2, start3;
    logic        in_valid, in_last;
    logic [2:0]  cls;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        f7b5;
    logic [20:0] imm;

    logic        ready6, we6, err6, errS6, done6;
    logic [5:0]  addr6;
    logic [31:0] wdata6;
    logic [6:0]  count6;
    logic        ready2, we2, err2, errS2, done2;
    logic [1:0]  addr2;
    logic [31:0] wdata2;
    logic [2:0]  count2;
    logic        ready3, we3, err3, errS3, done3;
    logic [2:0]  addr3;
    logic [31:0] wdata3;
    logic [3:0]  count3;

    int checks = 0;
    int errors = 0;
    expT exp6[$];
    expT exp2[$];
    expT exp3[$];
    expT e6, e2, e3;

    always #5 clk = ~clk;

    instr_encoder_loader #(.AW(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .start(start6), .in_valid(in_valid), .in_ready(ready6),
        .in_last(in_last), .cls(cls), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .f7b5(f7b5), .imm(imm), .mem_we(we6), .mem_addr(addr6), .mem_wdata(wdata6),
        .err(err6), .err_sticky(errS6), .done(done6), .count(count6));

    instr_encoder_loader #(.AW(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid), .in_ready(ready2),
        .in_last(in_last), .cls(cls), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .f7b5(f7b5), .imm(imm), .mem_we(we2), .mem_addr(addr2), .mem_wdata(wdata2),
        .err(err2), .err_sticky(errS2), .done(done2), .count(count2));

    instr_encoder_loader #(.AW(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .in_valid(in_valid), .in_ready(ready3),
        .in_last(in_last), .cls(cls), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .f7b5(f7b5), .imm(imm), .mem_we(we3), .mem_addr(addr3), .mem_wdata(wdata3),
        .err(err3), .err_sticky(errS3), .done(done3), .count(count3));

    // Write scoreboards, sampled on the falling edge.
    always @(negedge clk) begin
        if (we6) begin
            checks++;
            if (exp6.size() == 0) begin
                errors++;
                $display("FAIL write6_unexpected addr=%0d data=%h", addr6, wdata6);
            end else begin
                e6 = exp6.pop_front();
                if (addr6 !== e6.a || wdata6 !== e6.d) begin
                    errors++;
                    $display("FAIL write6 got addr=%0d data=%h want addr=%0d data=%h", addr6, wdata6, e6.a, e6.d);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (we2) begin
            checks++;
            if (exp2.size() == 0) begin
                errors++;
                $display("FAIL write2_unexpected addr=%0d data=%h", addr2, wdata2);
            end else begin
                e2 = exp2.pop_front();
                if ({4'b0, addr2} !== e2.a || wdata2 !== e2.d) begin
                    errors++;
                    $display("FAIL write2 got addr=%0d data=%h want addr=%0d data=%h", addr2, wdata2, e2.a, e2.d);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (we3) begin
            checks++;
            if (exp3.size() == 0) begin
                errors++;
                $display("FAIL write3_unexpected addr=%0d data=%h", addr3, wdata3);
            end else begin
                e3 = exp3.pop_front();
                if ({3'b0, addr3} !== e3.a || wdata3 !== e3.d) begin
                    errors++;
                    $display("FAIL write3 got addr=%0d data=%h want addr=%0d data=%h", addr3, wdata3, e3.a, e3.d);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic pickReady(input int sel);
        return (sel == 0) ? ready6 : (sel == 1) ? ready2 : ready3;
    endfunction

    // Entered and left #1 after a rising edge.
    task automatic pulseStart(input int sel);
        start6 = (sel == 0);
        start2 = (sel == 1);
        start3 = (sel == 2);
        @(posedge clk); #1;
        start6 = 1'b0; start2 = 1'b0; start3 = 1'b0;
    endtask

    // Presents one tuple and returns #1 after the accepting edge.
    task automatic sendTuple(input int sel, input logic [2:0] c, input logic [4:0] d,
                             input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                             input logic b5, input logic [20:0] im, input logic last);
        int n;
        cls = c; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; f7b5 = b5; imm = im;
        in_last = last; in_valid = 1'b1;
        n = 0;
        while (!pickReady(sel) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!pickReady(sel)) begin
            checks++; errors++;
            $display("FAIL accept_timeout sel=%0d waited=%0d cycles", sel, n);
        end else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start6 = 0; start2 = 0; start3 = 0;
        in_valid = 0; in_last = 0; cls = 0; rd = 0; rs1 = 0; rs2 = 0; funct3 = 0; f7b5 = 0; imm = '0;
        #1 rst_n = 1'b0;
        #3;
        checks++;
        if ({ready6, we6, err6, errS6, done6, addr6, wdata6, count6} !== '0) begin
            errors++; $display("FAIL reset6 got %h want 0", {ready6, we6, err6, errS6, done6, addr6, wdata6, count6});
        end
        checks++;
        if ({ready2, we2, err2, errS2, done2, addr2, wdata2, count2} !== '0) begin
            errors++; $display("FAIL reset2 got %h want 0", {ready2, we2, err2, errS2, done2, addr2, wdata2, count2});
        end
        checks++;
        if ({ready3, we3, err3, errS3, done3, addr3, wdata3, count3} !== '0) begin
            errors++; $display("FAIL reset3 got %h want 0", {ready3, we3, err3, errS3, done3, addr3, wdata3, count3});
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        // A tuple offered in IDLE is ignored.
        cls = 3'b101; rd = 5'd1; imm = 21'sd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (ready6 !== 1'b0 || count6 !== 7'd0) begin
            errors++; $display("FAIL idle_ignore ready=%b count=%0d want 0/0", ready6, count6);
        end
    endtask

    task automatic test_opimm();
        pulseStart(0);
        checks++;
        if (ready6 !== 1'b1 || count6 !== 7'd0) begin
            errors++; $display("FAIL start_load ready=%b count=%0d want 1/0", ready6, count6);
        end
        exp6.push_back({6'd0, 32'h00500093});
        sendTuple(0, 3'b101, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'sd5, 1'b0);
        checks++;
        if (we6 !== 1'b1 || addr6 !== 6'd0 || count6 !== 7'd1) begin
            errors++; $display("FAIL opimm_write we=%b addr=%0d count=%0d want 1/0/1", we6, addr6, count6);
        end
    endtask

    task automatic test_store_r();
        exp6.push_back({6'd1, 32'h0020A423});
        exp6.push_back({6'd2, 32'h002081B3});
        sendTuple(0, 3'b001, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 21'sd8, 1'b0);
        sendTuple(0, 3'b010, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 21'sd0, 1'b0);
        checks++;
        if (count6 !== 7'd3 || addr6 !== 6'd2) begin
            errors++; $display("FAIL store_r count=%0d addr=%0d want 3/2", count6, addr6);
        end
    endtask

    task automatic test_reject();
        sendTuple(0, 3'b101, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'sd2048, 1'b0);
        checks++;
        if (err6 !== 1'b1 || we6 !== 1'b0 || errS6 !== 1'b1 || count6 !== 7'd3 || ready6 !== 1'b1) begin
            errors++; $display("FAIL rej_opimm err=%b we=%b sticky=%b count=%0d ready=%b want 1/0/1/3/1",
                               err6, we6, errS6, count6, ready6);
        end
        @(posedge clk); #1;
        checks++;
        if (err6 !== 1'b0 || errS6 !== 1'b1) begin
            errors++; $display("FAIL err_pulse err=%b sticky=%b want 0/1", err6, errS6);
        end
        pulseStart(0);
        checks++;
        if (count6 !== 7'd3 || errS6 !== 1'b1 || ready6 !== 1'b1) begin
            errors++; $display("FAIL start_in_load count=%0d sticky=%b ready=%b want 3/1/1", count6, errS6, ready6);
        end
        sendTuple(0, 3'b011, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 21'sd3, 1'b0);
        checks++;
        if (err6 !== 1'b1 || we6 !== 1'b0) begin
            errors++; $display("FAIL rej_branch_odd err=%b we=%b want 1/0", err6, we6);
        end
        sendTuple(0, 3'b111, 5'd1, 5'd1, 5'd2, 3'd0, 1'b0, 21'sd0, 1'b0);
        checks++;
        if (err6 !== 1'b1 || we6 !== 1'b0) begin
            errors++; $display("FAIL rej_cls7 err=%b we=%b want 1/0", err6, we6);
        end
        exp6.push_back({6'd3, 32'hFFC12283});
        sendTuple(0, 3'b000, 5'd5, 5'd2, 5'd0, 3'd0, 1'b0, -21'sd4, 1'b0);
        checks++;
        if (we6 !== 1'b1 || addr6 !== 6'd3 || err6 !== 1'b0 || count6 !== 7'd4) begin
            errors++; $display("FAIL after_reject we=%b addr=%0d err=%b count=%0d want 1/3/0/4", we6, addr6, err6, count6);
        end
    endtask

    task automatic test_boundary();
        exp6.push_back({6'd4, 32'h7FF00093});
        exp6.push_back({6'd5, 32'h80000093});
        sendTuple(0, 3'b101, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'sd2047, 1'b0);
        sendTuple(0, 3'b101, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, -21'sd2048, 1'b0);
        sendTuple(0, 3'b101, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, -21'sd2049, 1'b0);
        checks++;
        if (err6 !== 1'b1 || we6 !== 1'b0) begin
            errors++; $display("FAIL rej_opimm_low err=%b we=%b want 1/0", err6, we6);
        end
        exp6.push_back({6'd6, 32'h7E000FE3});
        sendTuple(0, 3'b011, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 21'sd4094, 1'b0);
        sendTuple(0, 3'b011, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 21'sd4096, 1'b0);
        checks++;
        if (err6 !== 1'b1 || we6 !== 1'b0) begin
            errors++; $display("FAIL rej_branch_high err=%b we=%b want 1/0", err6, we6);
        end
        exp6.push_back({6'd7, 32'h80000063});
        sendTuple(0, 3'b011, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, -21'sd4096, 1'b0);
        checks++;
        if (count6 !== 7'd8 || addr6 !== 6'd7) begin
            errors++; $display("FAIL boundary count=%0d addr=%0d want 8/7", count6, addr6);
        end
    endtask

    task automatic test_branch_jal_last();
        exp6.push_back({6'd8, 32'hFE208EE3});
        exp6.push_back({6'd9, 32'h008000EF});
        sendTuple(0, 3'b011, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, -21'sd4, 1'b0);
        sendTuple(0, 3'b100, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'sd8, 1'b1);
        checks++;
        if (we6 !== 1'b1 || done6 !== 1'b0 || ready6 !== 1'b0) begin
            errors++; $display("FAIL last_write we=%b done=%b ready=%b want 1/0/0", we6, done6, ready6);
        end
        @(posedge clk); #1;
        checks++;
        if (done6 !== 1'b1 || count6 !== 7'd10) begin
            errors++; $display("FAIL last_done done=%b count=%0d want 1/10", done6, count6);
        end
    endtask

    task automatic test_full();
        pulseStart(1);
        for (int k = 0; k < 4; k++) begin
            exp2.push_back({6'(k), 12'(k + 1), 5'd0, 3'd0, 5'(k + 1), 7'h13});
            sendTuple(1, 3'b101, 5'(k + 1), 5'd0, 5'd0, 3'd0, 1'b0, 21'(k + 1), 1'b0);
        end
        checks++;
        if (ready2 !== 1'b0 || count2 !== 3'd4 || done2 !== 1'b0) begin
            errors++; $display("FAIL full_ready ready=%b count=%0d done=%b want 0/4/0", ready2, count2, done2);
        end
        cls = 3'b101; rd = 5'd9; imm = 21'sd9; in_valid = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (done2 !== 1'b1 || ready2 !== 1'b0) begin
            errors++; $display("FAIL full_done done=%b ready=%b want 1/0", done2, ready2);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (count2 !== 3'd4 || addr2 !== 2'd3) begin
            errors++; $display("FAIL full_hold count=%0d addr=%0d want 4/3", count2, addr2);
        end
    endtask

    task automatic test_pad();
        int n;
        pulseStart(2);
        exp3.push_back({6'd0, 32'h00700113});
        exp3.push_back({6'd1, 32'h40208233});
`ifdef PAD_NOP_EN
        for (int a = 2; a < 8; a++) exp3.push_back({6'(a), 32'h00000013});
`endif
        sendTuple(2, 3'b101, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 21'sd7, 1'b0);
        sendTuple(2, 3'b010, 5'd4, 5'd1, 5'd2, 3'd0, 1'b1, 21'sd0, 1'b1);
        checks++;
        if (we3 !== 1'b1 || addr3 !== 3'd1 || ready3 !== 1'b0) begin
            errors++; $display("FAIL pad_last we=%b addr=%0d ready=%b want 1/1/0", we3, addr3, ready3);
        end
`ifdef PAD_NOP_EN
        for (int a = 2; a < 8; a++) begin
            @(posedge clk); #1;
            checks++;
            if (we3 !== 1'b1 || addr3 !== 3'(a) || ready3 !== 1'b0) begin
                errors++; $display("FAIL pad_cycle we=%b addr=%0d ready=%b want 1/%0d/0", we3, addr3, ready3, a);
            end
        end
`endif
        n = 0;
        while (!done3 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
`ifdef PAD_NOP_EN
        if (done3 !== 1'b1 || count3 !== 4'd8) begin
            errors++; $display("FAIL pad_done done=%b count=%0d want 1/8", done3, count3);
        end
`else
        if (done3 !== 1'b1 || count3 !== 4'd2 || n !== 1) begin
            errors++; $display("FAIL nopad_done done=%b count=%0d cycles=%0d want 1/2/1", done3, count3, n);
        end
`endif
    endtask

    task automatic test_reset_mid();
        pulseStart(0);
        checks++;
        if (count6 !== 7'd0 || errS6 !== 1'b0 || done6 !== 1'b0 || ready6 !== 1'b1) begin
            errors++; $display("FAIL restart count=%0d sticky=%b done=%b ready=%b want 0/0/0/1",
                               count6, errS6, done6, ready6);
        end
        sendTuple(0, 3'b101, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'sd5, 1'b0);
        checks++;
        if (we6 !== 1'b1) begin
            errors++; $display("FAIL inflight we=%b want 1", we6);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({ready6, we6, err6, errS6, done6, addr6, wdata6, count6} !== '0) begin
            errors++; $display("FAIL reset_mid6 got %h want 0", {ready6, we6, err6, errS6, done6, addr6, wdata6, count6});
        end
        checks++;
        if ({done2, count2, done3, count3} !== '0) begin
            errors++; $display("FAIL reset_mid_other got %h want 0", {done2, count2, done3, count3});
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_opimm();
        test_store_r();
        test_reject();
        test_boundary();
        test_branch_jal_last();
        test_full();
        test_pad();
        test_reset_mid();
        checks++;
        if (exp6.size() != 0 || exp2.size() != 0 || exp3.size() != 0) begin
            errors++; $display("FAIL pending_writes got %0d/%0d/%0d want 0/0/0", exp6.size(), exp2.size(), exp3.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
